// File: rtl/mem_stage.sv
// Memory-access stage between execute and write-back: req/gnt/rvalid data port,
// store lane alignment, load extension. Optional watchdog enabled by MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int XLEN           = 32,
  parameter int RD_W           = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_reg_write,
  output logic            mem_err,
  output logic [XLEN-1:0] mem_err_addr
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("mem_stage supports XLEN=32 only");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RETIRE} state_e;

  state_e          state_q;
  logic            req_q, we_q, is_load_q, rw_q;
  logic [3:0]      be_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] eff_addr_q, wdata_q;
  logic            wb_valid_q, wb_reg_write_q, mem_err_q;
  logic [XLEN-1:0] wb_data_q, mem_err_addr_q;
  logic [RD_W-1:0] wb_rd_q;

  logic            is_mem, acc_err, timeout_hit;
  logic [1:0]      off;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d, load_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign is_mem = ex_mem_read | ex_mem_write;
  assign off    = ex_alu_out[1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_err = 1'b0;
    if (ex_mem_read && ex_mem_write)
      acc_err = 1'b1;
    else if (is_mem && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111))
      acc_err = 1'b1;
    else if (is_mem && ex_funct3[1:0] == 2'b01 && off[0])
      acc_err = 1'b1;
    else if (is_mem && ex_funct3 == 3'b010 && off != 2'b00)
      acc_err = 1'b1;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ex_rs2_data;
    case (ex_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{ex_rs2_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << off;
        wdata_d = {2{ex_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (eff_addr_q[1:0])
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      2'b11:   ld_byte = dmem_rdata[31:24];
      default: ;
    endcase
    ld_half   = eff_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'd0, ld_half};
      default: ;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
  assign timeout_hit = (cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      is_load_q      <= 1'b0;
      rw_q           <= 1'b0;
      be_q           <= '0;
      f3_q           <= '0;
      eff_addr_q     <= '0;
      wdata_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      mem_err_q      <= 1'b0;
      wb_data_q      <= '0;
      mem_err_addr_q <= '0;
      wb_rd_q        <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      // Retire outputs are single-cycle pulses unless re-armed below.
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      mem_err_q      <= 1'b0;
      case (state_q)
        IDLE: if (ex_valid) begin
          wb_rd_q    <= ex_rd;
          rw_q       <= ex_reg_write;
          f3_q       <= ex_funct3;
          eff_addr_q <= ex_alu_out;
          is_load_q  <= ex_mem_read;
          if (acc_err) begin
            state_q        <= RETIRE;
            wb_valid_q     <= 1'b1;
            wb_data_q      <= '0;
            mem_err_q      <= 1'b1;
            mem_err_addr_q <= ex_alu_out;
          end else if (!is_mem) begin
            state_q        <= RETIRE;
            wb_valid_q     <= 1'b1;
            wb_data_q      <= ex_alu_out;
            wb_reg_write_q <= ex_reg_write;
          end else begin
            state_q <= REQ;
            req_q   <= 1'b1;
            we_q    <= ex_mem_write;
            be_q    <= be_d;
            wdata_q <= wdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        REQ: begin
          if (dmem_gnt || timeout_hit) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            be_q  <= '0;
          end
          if (dmem_gnt) begin
            if (is_load_q) begin
              state_q <= WAIT;
            end else begin
              state_q    <= RETIRE;
              wb_valid_q <= 1'b1;
              wb_data_q  <= '0;
            end
          end else if (timeout_hit) begin
            state_q        <= RETIRE;
            wb_valid_q     <= 1'b1;
            wb_data_q      <= '0;
            mem_err_q      <= 1'b1;
            mem_err_addr_q <= eff_addr_q;
          end
`ifdef MEM_TIMEOUT_EN
          else cnt_q <= cnt_q + CNT_W'(1);
`endif
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state_q        <= RETIRE;
            wb_valid_q     <= 1'b1;
            wb_data_q      <= load_data;
            wb_reg_write_q <= rw_q;
          end else if (timeout_hit) begin
            state_q        <= RETIRE;
            wb_valid_q     <= 1'b1;
            wb_data_q      <= '0;
            mem_err_q      <= 1'b1;
            mem_err_addr_q <= eff_addr_q;
          end
`ifdef MEM_TIMEOUT_EN
          else cnt_q <= cnt_q + CNT_W'(1);
`endif
        end
        RETIRE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = {eff_addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign mem_err      = mem_err_q;
  assign mem_err_addr = mem_err_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected retirements are queued at issue
// and compared by a monitor whenever wb_valid pulses.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_out, ex_rs2_data;
  logic        ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, mem_err;
  logic [31:0] mem_err_addr;

  mem_stage #(.XLEN(32), .RD_W(5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_err(mem_err), .mem_err_addr(mem_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
    logic [31:0] eaddr;
    logic        chk_data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Retirement monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wb_exp_t e;
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_spurious", 32'(wb_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        check("mem_err", 32'(mem_err), 32'(e.err));
        if (e.rw) check("wb_rd", 32'(wb_rd), 32'(e.rd));
        if (e.err) check("mem_err_addr", mem_err_addr, e.eaddr);
        if (e.chk_data) check("wb_data", wb_data, e.data);
      end
    end else if (mem_err === 1'b1) begin
      check("mem_err_orphan", 32'(mem_err), 32'd0);
    end
  end

  task automatic push(input logic [31:0] data, input logic [4:0] rd, input logic rw,
                      input logic err, input logic [31:0] eaddr, input logic chk);
    wb_exp_t e;
    e.data = data; e.rd = rd; e.rw = rw; e.err = err; e.eaddr = eaddr; e.chk_data = chk;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && ex_ready !== 1'b1; i++) @(negedge clk);
    check("ex_ready_wait", 32'(ex_ready), 32'd1);
  endtask

  // Presents one instruction for exactly one accepting edge; returns on the following negedge.
  task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic rd_en, input logic wr_en, input logic [2:0] f3);
    wait_ready();
    ex_alu_out   = alu;
    ex_rs2_data  = rs2;
    ex_rd        = rd;
    ex_reg_write = rw;
    ex_mem_read  = rd_en;
    ex_mem_write = wr_en;
    ex_funct3    = f3;
    ex_valid     = 1'b1;
    @(negedge clk);
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
  endtask

  task automatic do_alu(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
    push(alu, rd, rw, 1'b0, 32'd0, 1'b1);
    issue(alu, 32'h0, rd, rw, 1'b0, 1'b0, 3'b000);
    check("alu_no_req", 32'(dmem_req), 32'd0);
  endtask

  task automatic do_mem(input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [2:0] f3, input logic store, input int gnt_dly,
                        input int rv_dly, input logic [31:0] rdata, input logic [31:0] exp_data,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    push(exp_data, rd, !store, 1'b0, 32'd0, !store);
    issue(addr, rs2, rd, 1'b1, !store, store, f3);
    for (int i = 0; i <= gnt_dly; i++) begin
      check("req_held", 32'(dmem_req), 32'd1);
      check("req_addr", dmem_addr, {addr[31:2], 2'b00});
      check("req_we", 32'(dmem_we), 32'(store));
      check("busy_ready", 32'(ex_ready), 32'd0);
      if (store) begin
        check("req_be", 32'(dmem_be), 32'(exp_be));
        check("req_wdata", dmem_wdata, exp_wdata);
      end
      dmem_gnt = (i == gnt_dly);
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    check("req_drop", 32'(dmem_req), 32'd0);
    if (!store) begin
      for (int i = 1; i < rv_dly; i++) begin
        check("wait_ready", 32'(ex_ready), 32'd0);
        @(negedge clk);
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h5A5A_5A5A;
    end
  endtask

  task automatic do_err(input logic [31:0] addr, input logic [2:0] f3,
                        input logic rd_en, input logic wr_en);
    push(32'd0, 5'd9, 1'b0, 1'b1, addr, 1'b0);
    issue(addr, 32'hFFFF_FFFF, 5'd9, 1'b1, rd_en, wr_en, f3);
    check("err_no_req", 32'(dmem_req), 32'd0);
  endtask

  task automatic reset_mid(input logic in_wait);
    issue(32'h0000_0500, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010);
    if (in_wait) begin
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_drop", 32'(dmem_req), 32'd0);
    check("rst_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    repeat (2) begin
      check("rst_no_wb", 32'(wb_valid), 32'd0);
      @(negedge clk);
    end
    check("rst_idle_ready", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_alu_out = '0; ex_rs2_data = '0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_funct3 = '0; ex_rd = '0; ex_reg_write = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_alu(32'h0000_1234, 5'd5, 1'b1);
    do_alu(32'hFFFF_0000, 5'd0, 1'b0);

    // Stores: addr, rs2, rd, funct3, store, gnt delay, -, -, -, be, wdata
    do_mem(32'h0000_0103, 32'h0000_00AB, 5'd0, 3'b000, 1'b1, 3, 0, '0, '0, 4'b1000, 32'hABAB_ABAB);
    do_mem(32'h0000_0106, 32'h1234_5678, 5'd0, 3'b001, 1'b1, 0, 0, '0, '0, 4'b1100, 32'h5678_5678);
    do_mem(32'h0000_0108, 32'hCAFE_F00D, 5'd0, 3'b010, 1'b1, 1, 0, '0, '0, 4'b1111, 32'hCAFE_F00D);

    // Loads: addr, -, rd, funct3, load, gnt delay, rvalid delay, rdata, expected
    do_mem(32'h0000_0202, '0, 5'd7,  3'b001, 1'b0, 0, 2, 32'h8001_0000, 32'hFFFF_8001, '0, '0);
    do_mem(32'h0000_0202, '0, 5'd8,  3'b101, 1'b0, 0, 2, 32'h8001_0000, 32'h0000_8001, '0, '0);
    do_mem(32'h0000_0403, '0, 5'd10, 3'b000, 1'b0, 1, 1, 32'h8F12_3456, 32'hFFFF_FF8F, '0, '0);
    do_mem(32'h0000_0401, '0, 5'd11, 3'b100, 1'b0, 0, 1, 32'h0000_9A00, 32'h0000_009A, '0, '0);
    do_mem(32'h0000_0404, '0, 5'd12, 3'b010, 1'b0, 2, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, '0, '0);

    do_err(32'h0000_0301, 3'b010, 1'b1, 1'b0);
    do_err(32'h0000_0205, 3'b001, 1'b1, 1'b0);
    do_err(32'h0000_0400, 3'b011, 1'b1, 1'b0);
    do_err(32'h0000_0400, 3'b010, 1'b1, 1'b1);
    do_err(32'h0000_0410, 3'b110, 1'b0, 1'b1);

    reset_mid(1'b0);
    reset_mid(1'b1);

`ifdef MEM_TIMEOUT_EN
    begin
      int k;
      push(32'd0, 5'd4, 1'b0, 1'b1, 32'h0000_0600, 1'b0);
      issue(32'h0000_0600, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
      k = 0;
      while (wb_valid !== 1'b1 && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("timeout_latency", 32'(k), 32'd16);
      check("timeout_req_drop", 32'(dmem_req), 32'd0);
      @(negedge clk);
      check("timeout_ready", 32'(ex_ready), 32'd1);
    end
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
